// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared types and constants for the EXE hazard controller.
//   hazard_state_e : controller FSM states
//   fwd_sel_e      : EXE operand mux select encoding
//   REG_ADDR_W     : architectural register address width
package exe_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_BUSY  = 2'd1,
        MC_DRAIN = 2'd2
    } hazard_state_e;

    typedef enum logic [1:0] {
        FWD_EXE = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/exe_hazard_ctrl_fwd.sv
// Forwarding select for one EXE operand (pure combinational).
//   rs_addr_i            : source register read by the EXE instruction
//   mem_rd_addr_i/_we_i  : destination and write enable of the instruction in MEM
//   wb_rd_addr_i/_we_i   : destination and write enable of the instruction in WB
//   fwd_sel_o            : FWD_EXE / FWD_MEM / FWD_WB
module exe_fwd_unit
    import exe_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
    input  logic                  mem_we_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
    input  logic                  wb_we_i,
    output logic [1:0]            fwd_sel_o
);

    // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
    always_comb begin
        fwd_sel_o = FWD_EXE;
        if (mem_we_i && (mem_rd_addr_i != '0) && (mem_rd_addr_i == rs_addr_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (wb_we_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == rs_addr_i)) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Pipeline hazard controller for the EXE stage.
//   Inputs : ID/EXE/MEM/WB register addresses and write flags, load flag of the EXE instr,
//            pc_mux_sel (taken branch), mc_start/mc_done (multi-cycle EXE op handshake).
//   Outputs: ForwardA_sel/ForwardB_sel operand selects, PC_write/IF_ID_write enables,
//            IF_ID_flush/ID_EXE_flush/EXE_MEM_bubble bubble controls, EXE_hold for MC ops,
//            sticky mc_err timeout flag, perf_stall_cnt (cycles with PC frozen).
// Reset is synchronous and active-low; while rst is low all stage controls are forced safe.
module exe_hazard_ctrl
    import exe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_rs1_addr,
    input  logic [REG_ADDR_W-1:0] ID_rs2_addr,
    input  logic                  ID_rs1_used,
    input  logic                  ID_rs2_used,
    input  logic [REG_ADDR_W-1:0] EXE_rs1_addr,
    input  logic [REG_ADDR_W-1:0] EXE_rs2_addr,
    input  logic [REG_ADDR_W-1:0] ID_EXE_rd_addr,
    input  logic                  ID_EXE_DM_read,
    input  logic [REG_ADDR_W-1:0] EXE_MEM_rd_addr,
    input  logic                  EXE_MEM_reg_write,
    input  logic [REG_ADDR_W-1:0] MEM_WB_rd_addr,
    input  logic                  MEM_WB_reg_write,
    input  logic                  pc_mux_sel,
    input  logic                  mc_start,
    input  logic                  mc_done,
    output logic [1:0]            ForwardA_sel,
    output logic [1:0]            ForwardB_sel,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  IF_ID_flush,
    output logic                  ID_EXE_flush,
    output logic                  EXE_hold,
    output logic                  EXE_MEM_bubble,
    output logic                  mc_err,
    output logic [CNT_WIDTH-1:0]  perf_stall_cnt
);

    localparam int unsigned MC_CNT_W = $clog2(MC_TIMEOUT);
    localparam logic [MC_CNT_W-1:0] McCntLast = MC_CNT_W'(MC_TIMEOUT - 1);

    hazard_state_e          state_q, state_d;
    logic [MC_CNT_W-1:0]    mc_cnt_q, mc_cnt_d;
    logic                   mc_err_q, mc_err_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
    logic [1:0]             fwd_a, fwd_b;
    logic                   load_use;

    exe_fwd_unit u_fwd_a (
        .rs_addr_i     (EXE_rs1_addr),
        .mem_rd_addr_i (EXE_MEM_rd_addr),
        .mem_we_i      (EXE_MEM_reg_write),
        .wb_rd_addr_i  (MEM_WB_rd_addr),
        .wb_we_i       (MEM_WB_reg_write),
        .fwd_sel_o     (fwd_a)
    );

    exe_fwd_unit u_fwd_b (
        .rs_addr_i     (EXE_rs2_addr),
        .mem_rd_addr_i (EXE_MEM_rd_addr),
        .mem_we_i      (EXE_MEM_reg_write),
        .wb_rd_addr_i  (MEM_WB_rd_addr),
        .wb_we_i       (MEM_WB_reg_write),
        .fwd_sel_o     (fwd_b)
    );

    assign ForwardA_sel = rst ? fwd_a : FWD_EXE;
    assign ForwardB_sel = rst ? fwd_b : FWD_EXE;

    assign load_use = ID_EXE_DM_read && (ID_EXE_rd_addr != '0) &&
                      ((ID_rs1_used && (ID_EXE_rd_addr == ID_rs1_addr)) ||
                       (ID_rs2_used && (ID_EXE_rd_addr == ID_rs2_addr)));

    // Next state and Mealy stage controls.
    always_comb begin
        state_d        = state_q;
        PC_write       = 1'b1;
        IF_ID_write    = 1'b1;
        IF_ID_flush    = 1'b0;
        ID_EXE_flush   = 1'b0;
        EXE_hold       = 1'b0;
        EXE_MEM_bubble = 1'b0;

        unique case (state_q)
            RUN, MC_DRAIN: begin
                state_d = RUN;
                // In MC_DRAIN pc_mux_sel belongs to the finished MC op, which never branches.
                if (pc_mux_sel && (state_q == RUN)) begin
                    IF_ID_flush  = 1'b1;
                    ID_EXE_flush = 1'b1;
                end else if (mc_start && !mc_done) begin
                    PC_write       = 1'b0;
                    IF_ID_write    = 1'b0;
                    EXE_hold       = 1'b1;
                    EXE_MEM_bubble = 1'b1;
                    state_d        = MC_BUSY;
                end else if (load_use) begin
                    PC_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EXE_flush = 1'b1;
                end
            end
            MC_BUSY: begin
                // Front end stays frozen through the completion cycle; only the result moves.
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                if (mc_done) begin
                    state_d = MC_DRAIN;
                end else begin
                    EXE_hold       = 1'b1;
                    EXE_MEM_bubble = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (!rst) begin
            state_d        = RUN;
            PC_write       = 1'b0;
            IF_ID_write    = 1'b0;
            IF_ID_flush    = 1'b1;
            ID_EXE_flush   = 1'b1;
            EXE_hold       = 1'b0;
            EXE_MEM_bubble = 1'b1;
        end
    end

    // Timeout counter, sticky error and saturating stall counter.
    always_comb begin
        mc_cnt_d    = '0;
        mc_err_d    = mc_err_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == MC_BUSY && !mc_done) begin
            if (mc_cnt_q == McCntLast) begin
                mc_err_d = 1'b1;
                mc_cnt_d = mc_cnt_q;
            end else begin
                mc_cnt_d = mc_cnt_q + MC_CNT_W'(1);
            end
        end
        if (!PC_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            mc_cnt_q    <= '0;
            mc_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            mc_err_q    <= mc_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mc_err         = mc_err_q;
    assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl: forwarding, load-use, branch flush, MC op sequencing,
// timeout and reset behaviour.
module tb_exe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  ID_rs1_addr, ID_rs2_addr;
    logic        ID_rs1_used, ID_rs2_used;
    logic [4:0]  EXE_rs1_addr, EXE_rs2_addr, ID_EXE_rd_addr;
    logic        ID_EXE_DM_read;
    logic [4:0]  EXE_MEM_rd_addr, MEM_WB_rd_addr;
    logic        EXE_MEM_reg_write, MEM_WB_reg_write;
    logic        pc_mux_sel, mc_start, mc_done;
    logic [1:0]  ForwardA_sel, ForwardB_sel;
    logic        PC_write, IF_ID_write, IF_ID_flush, ID_EXE_flush;
    logic        EXE_hold, EXE_MEM_bubble, mc_err;
    logic [31:0] perf_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    exe_hazard_ctrl #(
        .MC_TIMEOUT (64),
        .CNT_WIDTH  (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ID_rs1_addr       (ID_rs1_addr),
        .ID_rs2_addr       (ID_rs2_addr),
        .ID_rs1_used       (ID_rs1_used),
        .ID_rs2_used       (ID_rs2_used),
        .EXE_rs1_addr      (EXE_rs1_addr),
        .EXE_rs2_addr      (EXE_rs2_addr),
        .ID_EXE_rd_addr    (ID_EXE_rd_addr),
        .ID_EXE_DM_read    (ID_EXE_DM_read),
        .EXE_MEM_rd_addr   (EXE_MEM_rd_addr),
        .EXE_MEM_reg_write (EXE_MEM_reg_write),
        .MEM_WB_rd_addr    (MEM_WB_rd_addr),
        .MEM_WB_reg_write  (MEM_WB_reg_write),
        .pc_mux_sel        (pc_mux_sel),
        .mc_start          (mc_start),
        .mc_done           (mc_done),
        .ForwardA_sel      (ForwardA_sel),
        .ForwardB_sel      (ForwardB_sel),
        .PC_write          (PC_write),
        .IF_ID_write       (IF_ID_write),
        .IF_ID_flush       (IF_ID_flush),
        .ID_EXE_flush      (ID_EXE_flush),
        .EXE_hold          (EXE_hold),
        .EXE_MEM_bubble    (EXE_MEM_bubble),
        .mc_err            (mc_err),
        .perf_stall_cnt    (perf_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic clr_inputs();
        ID_rs1_addr = '0; ID_rs2_addr = '0; ID_rs1_used = 1'b0; ID_rs2_used = 1'b0;
        EXE_rs1_addr = '0; EXE_rs2_addr = '0; ID_EXE_rd_addr = '0; ID_EXE_DM_read = 1'b0;
        EXE_MEM_rd_addr = '0; EXE_MEM_reg_write = 1'b0;
        MEM_WB_rd_addr = '0; MEM_WB_reg_write = 1'b0;
        pc_mux_sel = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_pcw"},   {31'd0, PC_write},       32'd0);
        check_val({tag, "_ifw"},   {31'd0, IF_ID_write},    32'd0);
        check_val({tag, "_iff"},   {31'd0, IF_ID_flush},    32'd1);
        check_val({tag, "_idf"},   {31'd0, ID_EXE_flush},   32'd1);
        check_val({tag, "_hold"},  {31'd0, EXE_hold},       32'd0);
        check_val({tag, "_bub"},   {31'd0, EXE_MEM_bubble}, 32'd1);
        check_val({tag, "_fwda"},  {30'd0, ForwardA_sel},   32'd0);
    endtask

    int n_pcw0;
    int n_bub;

    initial begin
        clr_inputs();
        rst = 1'b0;
        // Forwarding match present during reset must still read as 0.
        EXE_MEM_rd_addr = 5'd5; EXE_MEM_reg_write = 1'b1; EXE_rs1_addr = 5'd5;
        settle();
        check_reset_outs("rst");
        tick();
        tick();
        check_val("rst_cnt", perf_stall_cnt, 32'd0);
        check_val("rst_err", {31'd0, mc_err}, 32'd0);

        // Idle run
        clr_inputs();
        rst = 1'b1;
        settle();
        check_val("idle_pcw", {31'd0, PC_write}, 32'd1);
        check_val("idle_iff", {31'd0, IF_ID_flush}, 32'd0);
        check_val("idle_bub", {31'd0, EXE_MEM_bubble}, 32'd0);

        // Forwarding: MEM beats WB, WB alone, x0 never, write enable respected
        EXE_MEM_rd_addr = 5'd5; EXE_MEM_reg_write = 1'b1;
        MEM_WB_rd_addr = 5'd5; MEM_WB_reg_write = 1'b1; EXE_rs1_addr = 5'd5;
        settle();
        check_val("fwdA_mem", {30'd0, ForwardA_sel}, 32'd1);
        EXE_MEM_reg_write = 1'b0;
        settle();
        check_val("fwdA_wb", {30'd0, ForwardA_sel}, 32'd2);
        EXE_MEM_rd_addr = 5'd0; EXE_MEM_reg_write = 1'b1; MEM_WB_rd_addr = 5'd0;
        EXE_rs1_addr = 5'd0;
        settle();
        check_val("fwdA_x0", {30'd0, ForwardA_sel}, 32'd0);
        EXE_MEM_rd_addr = 5'd7; EXE_MEM_reg_write = 1'b0;
        MEM_WB_rd_addr = 5'd7; MEM_WB_reg_write = 1'b1; EXE_rs2_addr = 5'd7;
        settle();
        check_val("fwdB_wb", {30'd0, ForwardB_sel}, 32'd2);
        check_val("fwdA_nomatch", {30'd0, ForwardA_sel}, 32'd0);
        EXE_MEM_reg_write = 1'b1;
        settle();
        check_val("fwdB_mem", {30'd0, ForwardB_sel}, 32'd1);
        tick();

        // Load-use: lw x3 in EXE, ID add reads x3 on rs2
        clr_inputs();
        ID_EXE_DM_read = 1'b1; ID_EXE_rd_addr = 5'd3; ID_rs2_addr = 5'd3; ID_rs2_used = 1'b1;
        ID_rs1_addr = 5'd9; ID_rs1_used = 1'b1;
        settle();
        check_val("lu_pcw", {31'd0, PC_write}, 32'd0);
        check_val("lu_ifw", {31'd0, IF_ID_write}, 32'd0);
        check_val("lu_idf", {31'd0, ID_EXE_flush}, 32'd1);
        check_val("lu_iff", {31'd0, IF_ID_flush}, 32'd0);
        tick();
        // Bubble in EXE, load in MEM: no more stall
        clr_inputs();
        EXE_MEM_rd_addr = 5'd3; EXE_MEM_reg_write = 1'b1;
        ID_rs2_addr = 5'd3; ID_rs2_used = 1'b1;
        settle();
        check_val("lu_cnt", perf_stall_cnt, 32'd1);
        check_val("lu_nostall", {31'd0, PC_write}, 32'd1);
        tick();
        // add in EXE, load now in WB
        clr_inputs();
        EXE_rs2_addr = 5'd3; MEM_WB_rd_addr = 5'd3; MEM_WB_reg_write = 1'b1;
        settle();
        check_val("lu_fwdB", {30'd0, ForwardB_sel}, 32'd2);
        // Load-use on rs1 with rs1_used low: no hazard
        ID_EXE_DM_read = 1'b1; ID_EXE_rd_addr = 5'd4; ID_rs1_addr = 5'd4; ID_rs1_used = 1'b0;
        settle();
        check_val("lu_unused", {31'd0, PC_write}, 32'd1);
        tick();

        // Taken branch beats load-use
        clr_inputs();
        ID_EXE_DM_read = 1'b1; ID_EXE_rd_addr = 5'd3; ID_rs1_addr = 5'd3; ID_rs1_used = 1'b1;
        pc_mux_sel = 1'b1;
        settle();
        check_val("br_iff", {31'd0, IF_ID_flush}, 32'd1);
        check_val("br_idf", {31'd0, ID_EXE_flush}, 32'd1);
        check_val("br_pcw", {31'd0, PC_write}, 32'd1);
        tick();
        clr_inputs();
        settle();
        check_val("br_cnt", perf_stall_cnt, 32'd1);

        // Single-cycle op: start and done together
        mc_start = 1'b1; mc_done = 1'b1;
        settle();
        check_val("sc_pcw", {31'd0, PC_write}, 32'd1);
        check_val("sc_hold", {31'd0, EXE_hold}, 32'd0);
        tick();

        // Multi-cycle op, done on the 5th cycle after start
        clr_inputs();
        n_pcw0 = 0;
        n_bub = 0;
        mc_start = 1'b1;
        settle();
        check_val("mc_hold0", {31'd0, EXE_hold}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) mc_start = 1'b0;
            mc_done = (c == 5);
            settle();
            if (!PC_write) n_pcw0++;
            if (EXE_MEM_bubble) n_bub++;
            tick();
        end
        check_val("mc_pcw0_cycles", n_pcw0, 32'd6);
        check_val("mc_bub_cycles", n_bub, 32'd5);
        // Drain cycle: stale pc_mux_sel ignored
        clr_inputs();
        pc_mux_sel = 1'b1;
        settle();
        check_val("drain_iff", {31'd0, IF_ID_flush}, 32'd0);
        check_val("drain_pcw", {31'd0, PC_write}, 32'd1);
        check_val("mc_cnt", perf_stall_cnt, 32'd7);
        tick();
        clr_inputs();
        settle();
        check_val("run_again", {31'd0, PC_write}, 32'd1);
        tick();

        // Timeout: no done, error registers after the 64th busy cycle
        mc_start = 1'b1;
        settle();
        tick();
        mc_start = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            settle();
            if (k == 63) check_val("to_err63", {31'd0, mc_err}, 32'd0);
            if (k == 64) check_val("to_err64", {31'd0, mc_err}, 32'd0);
            if (k == 65) check_val("to_err65", {31'd0, mc_err}, 32'd1);
            if (k == 70) begin
                check_val("to_err70", {31'd0, mc_err}, 32'd1);
                check_val("to_hold70", {31'd0, EXE_hold}, 32'd1);
            end
            tick();
        end
        rst = 1'b0;
        settle();
        check_reset_outs("to_rst");
        tick();
        rst = 1'b1;
        settle();
        check_val("to_err_clr", {31'd0, mc_err}, 32'd0);
        check_val("to_run", {31'd0, PC_write}, 32'd1);
        check_val("to_cnt_clr", perf_stall_cnt, 32'd0);
        tick();

        // Reset during MC_BUSY (3rd busy cycle)
        mc_start = 1'b1;
        settle();
        tick();
        mc_start = 1'b0;
        tick();
        tick();
        settle();
        check_val("mr_busy", {31'd0, EXE_hold}, 32'd1);
        rst = 1'b0;
        settle();
        check_reset_outs("mr_rst");
        tick();
        rst = 1'b1;
        settle();
        check_val("mr_run_pcw", {31'd0, PC_write}, 32'd1);
        check_val("mr_run_hold", {31'd0, EXE_hold}, 32'd0);
        check_val("mr_cnt", perf_stall_cnt, 32'd0);
        check_val("mr_err", {31'd0, mc_err}, 32'd0);
        tick();
        settle();
        check_val("mr_stay_run", {31'd0, PC_write}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
